pipeline_stall_controller: RTL and testbench

PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

---
 rtl/pipeline_stall_controller_if.sv | 27 ++
 rtl/pipeline_stall_controller.sv | 122 ++++++++++++
 tb/tb_pipeline_stall_controller.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_stall_controller_if.sv
// Handshake bundle between the hazard/memory sources and the stall controller.
// master drives the hazard and memory status, slave returns the pipeline controls.
interface pipeline_stall_controller_if;
   logic        hdu_stall;
   logic        branch_taken;
   logic        dmem_req;
   logic        dmem_ready;
   logic        pc_write;
   logic        if_id_write;
   logic        if_id_flush;
   logic        id_ex_bubble;
   logic        pipe_hold;
   logic        mem_fault;
   logic [15:0] stall_count;

   modport master (
      output hdu_stall, branch_taken, dmem_req, dmem_ready,
      input  pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold,
             mem_fault, stall_count
   );

   modport slave (
      input  hdu_stall, branch_taken, dmem_req, dmem_ready,
      output pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold,
             mem_fault, stall_count
   );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush controller: arbitrates memory waits, taken branches and
// load-use hazards, declares a sticky fault on data-memory timeout and counts
// stalled cycles.
module pipeline_stall_controller #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic                          clk,
   input  logic                          rst_n,
   pipeline_stall_controller_if.slave    bus
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FAULT    = 2'd2
   } state_t;

   localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

   state_t      state_q, state_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic        mem_fault_q, mem_fault_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;

   logic pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold;

   // Next state and control outputs; outputs are forced idle while reset is held.
   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      pipe_hold    = 1'b0;
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      mem_fault_d  = mem_fault_q;

      case (state_q)
         RUN: begin
            if (bus.dmem_req && !bus.dmem_ready) begin
               pc_write    = 1'b0;
               if_id_write = 1'b0;
               pipe_hold   = 1'b1;
               state_d     = MEM_WAIT;
               wait_cnt_d  = 8'd1;
            end else if (bus.branch_taken) begin
               // Wrong-path instructions in IF/ID and ID are squashed; the
               // load-use request refers to a squashed instruction.
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b1;
            end else if (bus.hdu_stall) begin
               pc_write     = 1'b0;
               if_id_write  = 1'b0;
               id_ex_bubble = 1'b1;
            end
         end
         MEM_WAIT: begin
            // Whole pipe frozen; branch/hazard requests are re-seen in RUN.
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_hold   = 1'b1;
            if (bus.dmem_ready) begin
               state_d    = RUN;
               wait_cnt_d = 8'd0;
            end else if (({1'b0, wait_cnt_q} + 9'd1) >= {1'b0, TIMEOUT}) begin
               // Saturate at the limit so the counter never passes it.
               state_d     = FAULT;
               mem_fault_d = 1'b1;
               wait_cnt_d  = TIMEOUT;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         FAULT: begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_hold   = 1'b1;
            mem_fault_d = 1'b1;
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = 8'd0;
         end
      endcase

      if (!rst_n) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         if_id_flush  = 1'b0;
         id_ex_bubble = 1'b0;
         pipe_hold    = 1'b0;
      end

      stall_cnt_d = stall_cnt_q;
      if (!pc_write && stall_cnt_q != 16'hFFFF)
         stall_cnt_d = stall_cnt_q + 16'd1;
   end

   // State, wait counter, sticky fault and saturating stall counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         wait_cnt_q  <= 8'd0;
         mem_fault_q <= 1'b0;
         stall_cnt_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         mem_fault_q <= mem_fault_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.pc_write     = pc_write;
   assign bus.if_id_write  = if_id_write;
   assign bus.if_id_flush  = if_id_flush;
   assign bus.id_ex_bubble = id_ex_bubble;
   assign bus.pipe_hold    = pipe_hold;
   assign bus.mem_fault    = mem_fault_q;
   assign bus.stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller (MEM_TIMEOUT = 15).
module tb_pipeline_stall_controller;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   pipeline_stall_controller_if bus ();

   pipeline_stall_controller #(.MEM_TIMEOUT(15)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n            = 1'b0;
      bus.hdu_stall    = 1'b0;
      bus.branch_taken = 1'b0;
      bus.dmem_req     = 1'b0;
      bus.dmem_ready   = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n            = 1'b0;
      bus.hdu_stall    = 1'b1;
      bus.branch_taken = 1'b1;
      bus.dmem_req     = 1'b1;
      bus.dmem_ready   = 1'b0;
      #1;
      checks++; if (bus.pc_write !== 1'b0) begin errors++; $display("FAIL reset_pc_write got=%b exp=0", bus.pc_write); end
      checks++; if (bus.if_id_write !== 1'b0) begin errors++; $display("FAIL reset_if_id_write got=%b exp=0", bus.if_id_write); end
      checks++; if (bus.if_id_flush !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b exp=0", bus.if_id_flush); end
      checks++; if (bus.id_ex_bubble !== 1'b0) begin errors++; $display("FAIL reset_bubble got=%b exp=0", bus.id_ex_bubble); end
      checks++; if (bus.pipe_hold !== 1'b0) begin errors++; $display("FAIL reset_hold got=%b exp=0", bus.pipe_hold); end
      checks++; if (bus.mem_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", bus.mem_fault); end
      checks++; if (bus.stall_count !== 16'd0) begin errors++; $display("FAIL reset_stall_count got=%0d exp=0", bus.stall_count); end
      do_reset();
      #1;
      checks++; if (bus.pc_write !== 1'b1) begin errors++; $display("FAIL reset_release_pc_write got=%b exp=1", bus.pc_write); end
   endtask

   task automatic test_load_use();
      do_reset();
      bus.hdu_stall = 1'b1;
      #1;
      checks++; if (bus.pc_write !== 1'b0) begin errors++; $display("FAIL lu_pc_write got=%b exp=0", bus.pc_write); end
      checks++; if (bus.if_id_write !== 1'b0) begin errors++; $display("FAIL lu_if_id_write got=%b exp=0", bus.if_id_write); end
      checks++; if (bus.id_ex_bubble !== 1'b1) begin errors++; $display("FAIL lu_bubble got=%b exp=1", bus.id_ex_bubble); end
      checks++; if (bus.if_id_flush !== 1'b0 || bus.pipe_hold !== 1'b0) begin errors++; $display("FAIL lu_flush_hold got=%b%b exp=00", bus.if_id_flush, bus.pipe_hold); end
      tick();
      bus.hdu_stall = 1'b0;
      #1;
      checks++; if (bus.pc_write !== 1'b1) begin errors++; $display("FAIL lu_next_pc_write got=%b exp=1", bus.pc_write); end
      checks++; if (bus.stall_count !== 16'd1) begin errors++; $display("FAIL lu_stall_count got=%0d exp=1", bus.stall_count); end
   endtask

   task automatic test_branch();
      bus.branch_taken = 1'b1;
      bus.hdu_stall    = 1'b1;
      #1;
      checks++; if (bus.if_id_flush !== 1'b1) begin errors++; $display("FAIL br_flush got=%b exp=1", bus.if_id_flush); end
      checks++; if (bus.id_ex_bubble !== 1'b1) begin errors++; $display("FAIL br_bubble got=%b exp=1", bus.id_ex_bubble); end
      checks++; if (bus.pc_write !== 1'b1 || bus.if_id_write !== 1'b1) begin errors++; $display("FAIL br_writes got=%b%b exp=11", bus.pc_write, bus.if_id_write); end
      checks++; if (bus.pipe_hold !== 1'b0) begin errors++; $display("FAIL br_hold got=%b exp=0", bus.pipe_hold); end
      tick();
      bus.branch_taken = 1'b0;
      bus.hdu_stall    = 1'b0;
      bus.dmem_req     = 1'b1;
      bus.dmem_ready   = 1'b1;
      #1;
      checks++; if (bus.stall_count !== 16'd1) begin errors++; $display("FAIL br_stall_count got=%0d exp=1", bus.stall_count); end
      checks++; if (bus.pc_write !== 1'b1 || bus.pipe_hold !== 1'b0) begin errors++; $display("FAIL hit_run got pc=%b hold=%b exp pc=1 hold=0", bus.pc_write, bus.pipe_hold); end
      tick();
      bus.dmem_req   = 1'b0;
      bus.dmem_ready = 1'b0;
   endtask

   task automatic test_mem_wait();
      do_reset();
      bus.dmem_req   = 1'b1;
      bus.dmem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) bus.dmem_ready = 1'b1;
         #1;
         checks++; if (bus.pipe_hold !== 1'b1 || bus.pc_write !== 1'b0) begin errors++; $display("FAIL mw_cycle%0d got hold=%b pc=%b exp hold=1 pc=0", i, bus.pipe_hold, bus.pc_write); end
         tick();
      end
      bus.dmem_req   = 1'b0;
      bus.dmem_ready = 1'b0;
      #1;
      checks++; if (bus.pc_write !== 1'b1 || bus.pipe_hold !== 1'b0) begin errors++; $display("FAIL mw_return got pc=%b hold=%b exp pc=1 hold=0", bus.pc_write, bus.pipe_hold); end
      checks++; if (bus.stall_count !== 16'd4) begin errors++; $display("FAIL mw_stall_count got=%0d exp=4", bus.stall_count); end
      checks++; if (bus.mem_fault !== 1'b0) begin errors++; $display("FAIL mw_fault got=%b exp=0", bus.mem_fault); end
   endtask

   task automatic test_branch_in_wait();
      do_reset();
      bus.dmem_req   = 1'b1;
      bus.dmem_ready = 1'b0;
      tick();
      bus.dmem_req     = 1'b0;
      bus.branch_taken = 1'b1;
      bus.hdu_stall    = 1'b1;
      #1;
      checks++; if (bus.if_id_flush !== 1'b0 || bus.id_ex_bubble !== 1'b0) begin errors++; $display("FAIL bw_wait got flush=%b bubble=%b exp 0 0", bus.if_id_flush, bus.id_ex_bubble); end
      tick();
      bus.dmem_ready = 1'b1;
      #1;
      checks++; if (bus.if_id_flush !== 1'b0 || bus.pipe_hold !== 1'b1) begin errors++; $display("FAIL bw_ready got flush=%b hold=%b exp 0 1", bus.if_id_flush, bus.pipe_hold); end
      tick();
      bus.dmem_ready = 1'b0;
      #1;
      checks++; if (bus.if_id_flush !== 1'b1 || bus.pc_write !== 1'b1) begin errors++; $display("FAIL bw_run got flush=%b pc=%b exp 1 1", bus.if_id_flush, bus.pc_write); end
      tick();
      bus.branch_taken = 1'b0;
      bus.hdu_stall    = 1'b0;
   endtask

   task automatic test_ready_at_timeout();
      do_reset();
      bus.dmem_req   = 1'b1;
      bus.dmem_ready = 1'b0;
      repeat (14) tick();
      bus.dmem_ready = 1'b1;
      #1;
      checks++; if (bus.pipe_hold !== 1'b1 || bus.mem_fault !== 1'b0) begin errors++; $display("FAIL rt_edge14 got hold=%b fault=%b exp 1 0", bus.pipe_hold, bus.mem_fault); end
      tick();
      bus.dmem_req   = 1'b0;
      bus.dmem_ready = 1'b0;
      #1;
      checks++; if (bus.pc_write !== 1'b1 || bus.pipe_hold !== 1'b0) begin errors++; $display("FAIL rt_run got pc=%b hold=%b exp 1 0", bus.pc_write, bus.pipe_hold); end
      checks++; if (bus.mem_fault !== 1'b0) begin errors++; $display("FAIL rt_fault got=%b exp=0", bus.mem_fault); end
      checks++; if (bus.stall_count !== 16'd15) begin errors++; $display("FAIL rt_stall_count got=%0d exp=15", bus.stall_count); end
   endtask

   task automatic test_timeout_fault();
      do_reset();
      bus.dmem_req   = 1'b1;
      bus.dmem_ready = 1'b0;
      repeat (14) tick();
      #1;
      checks++; if (bus.mem_fault !== 1'b0 || bus.pipe_hold !== 1'b1) begin errors++; $display("FAIL to_edge14 got fault=%b hold=%b exp 0 1", bus.mem_fault, bus.pipe_hold); end
      tick();
      #1;
      checks++; if (bus.mem_fault !== 1'b1) begin errors++; $display("FAIL to_edge15 got fault=%b exp=1", bus.mem_fault); end
      bus.dmem_req   = 1'b0;
      bus.dmem_ready = 1'b1;
      #1;
      checks++; if (bus.pipe_hold !== 1'b1 || bus.pc_write !== 1'b0) begin errors++; $display("FAIL to_fault_out got hold=%b pc=%b exp 1 0", bus.pipe_hold, bus.pc_write); end
      repeat (2) tick();
      #1;
      checks++; if (bus.mem_fault !== 1'b1 || bus.pipe_hold !== 1'b1) begin errors++; $display("FAIL to_sticky got fault=%b hold=%b exp 1 1", bus.mem_fault, bus.pipe_hold); end
      checks++; if (bus.stall_count !== 16'd17) begin errors++; $display("FAIL to_stall_count got=%0d exp=17", bus.stall_count); end
   endtask

   // Continues from the FAULT state left by test_timeout_fault (count = 17).
   task automatic test_saturate_and_reset();
      repeat (16'hFFFE - 17) tick();
      #1;
      checks++; if (bus.stall_count !== 16'hFFFE) begin errors++; $display("FAIL sat_fffe got=%h exp=fffe", bus.stall_count); end
      repeat (3) tick();
      #1;
      checks++; if (bus.stall_count !== 16'hFFFF) begin errors++; $display("FAIL sat_ffff got=%h exp=ffff", bus.stall_count); end
      rst_n = 1'b0;
      #1;
      checks++; if ({bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble, bus.pipe_hold} !== 5'b0) begin errors++; $display("FAIL mid_reset_ctl got=%b exp=00000", {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble, bus.pipe_hold}); end
      checks++; if (bus.mem_fault !== 1'b0) begin errors++; $display("FAIL mid_reset_fault got=%b exp=0", bus.mem_fault); end
      checks++; if (bus.stall_count !== 16'd0) begin errors++; $display("FAIL mid_reset_count got=%0d exp=0", bus.stall_count); end
      tick();
      rst_n          = 1'b1;
      bus.dmem_ready = 1'b0;
      #1;
      checks++; if (bus.pc_write !== 1'b1 || bus.pipe_hold !== 1'b0) begin errors++; $display("FAIL post_reset_run got pc=%b hold=%b exp 1 0", bus.pc_write, bus.pipe_hold); end
      tick();
      #1;
      checks++; if (bus.stall_count !== 16'd0) begin errors++; $display("FAIL post_reset_count got=%0d exp=0", bus.stall_count); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_load_use();
      test_branch();
      test_mem_wait();
      test_branch_in_wait();
      test_ready_at_timeout();
      test_timeout_fault();
      test_saturate_and_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
